// File: rtl/clint_mmio_if.sv
// LSU-facing request/response channel of the CLINT bridge.
// The LSU side is the master modport and the bridge side is the slave modport.
interface clint_mmio_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/clint_mmio_bridge.sv
// Bus front end of the machine timer: decodes single-beat LSU accesses to
// mtime/mtimecmp and issues one timer strobe cycle per accepted request.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | one-cycle timer strobe, response is latched on this edge
// RESP   | response held until the LSU accepts it
module clint_mmio_bridge #(
    parameter logic [63:0] BASE         = 64'h0000_0000_0200_0000,
    parameter logic [15:0] MTIMECMP_OFF = 16'h4000,
    parameter logic [15:0] MTIME_OFF    = 16'hBFF8
) (
    input  logic        clk,
    input  logic        rst,
    clint_mmio_if.slave bus,
    output logic        tmr_enable,
    output logic [1:0]  tmr_rw_mode,
    output logic [63:0] tmr_wdata,
    input  logic [63:0] tmr_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        cap_wen;
    logic [63:0] cap_addr;
    logic        hit;
    logic [1:0]  dec_mode;
    logic        dec_err;

    always_comb begin
        hit      = (cap_addr[63:16] == BASE[63:16]) && (cap_addr[2:0] == 3'b000);
        dec_mode = 2'd0;
        dec_err  = 1'b1;
        if (hit) begin
            if (!cap_wen && cap_addr[15:0] == MTIME_OFF) begin
                dec_mode = 2'd1;
                dec_err  = 1'b0;
            end else if (!cap_wen && cap_addr[15:0] == MTIMECMP_OFF) begin
                dec_mode = 2'd2;
                dec_err  = 1'b0;
            end else if (cap_wen && cap_addr[15:0] == MTIMECMP_OFF) begin
                dec_mode = 2'd3;
                dec_err  = 1'b0;
            end
        end
    end

    // The timer accumulates on every strobe cycle, so the mode is decoded
    // straight from ACCESS and drops to zero the moment reset hits.
    assign tmr_rw_mode = (state == ACCESS) ? dec_mode : 2'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cap_wen        <= 1'b0;
            cap_addr       <= 64'd0;
            tmr_enable     <= 1'b0;
            tmr_wdata      <= 64'd0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 64'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            tmr_enable <= 1'b1;
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        cap_wen       <= bus.req_wen;
                        cap_addr      <= bus.req_addr;
                        bus.req_ready <= 1'b0;
                        state         <= ACCESS;
                        // Store data is staged here so it is valid during the strobe.
                        if (bus.req_wen) tmr_wdata <= bus.req_wdata;
                    end
                end
                ACCESS: begin
                    bus.resp_rdata <= (dec_mode == 2'd1 || dec_mode == 2'd2) ? tmr_rdata : 64'd0;
                    bus.resp_err   <= dec_err;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clint_mmio_bridge.sv
// Scoreboard bench for clint_mmio_bridge: expected responses are queued at
// request time and compared when the bridge presents its response.
module tb_clint_mmio_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tmr_enable;
    logic [1:0]  tmr_rw_mode;
    logic [63:0] tmr_wdata;
    logic [63:0] tmr_rdata;
    logic [63:0] mtime_val    = 64'd0;
    logic [63:0] mtimecmp_val = 64'd0;

    clint_mmio_if bus ();

    clint_mmio_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tmr_enable  (tmr_enable),
        .tmr_rw_mode (tmr_rw_mode),
        .tmr_wdata   (tmr_wdata),
        .tmr_rdata   (tmr_rdata)
    );

    always #5 clk = ~clk;

    // Timer model: non-zero junk when not being read catches ungated rdata.
    assign tmr_rdata = (tmr_rw_mode == 2'd1) ? mtime_val :
                       (tmr_rw_mode == 2'd2) ? mtimecmp_val : 64'hFFFF_0000_FFFF_0000;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic [1:0]  mode;
        logic [63:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   strobe_cnt = 0;
    logic [1:0]  strobe_mode = 2'd0;
    logic [63:0] strobe_wdata = 64'd0;

    always @(negedge clk) begin
        if (tmr_rw_mode != 2'd0) begin
            strobe_cnt   = strobe_cnt + 1;
            strobe_mode  = tmr_rw_mode;
            strobe_wdata = tmr_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request, waits for its response, holds resp_ready low for
    // hold cycles (with a second request pending) and checks the result.
    task automatic do_txn(input string tag, input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_rdata,
                          input logic exp_err, input logic [1:0] exp_mode, input int hold);
        exp_t e;
        exp_t got_e;
        bit   acc = 0;
        int   lat = 0;
        e.rdata = exp_rdata; e.err = exp_err; e.mode = exp_mode; e.wdata = wdata;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wen    = wen;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = (hold == 0);
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_accept"}, 64'(acc), 64'd1);
        strobe_cnt = 0;
        strobe_mode = 2'd0;
        #1 bus.req_valid = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) break;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 64'd0, 64'd1);
            return;
        end
        got_e = exp_q.pop_front();
        chk({tag, "_rdata"}, bus.resp_rdata, got_e.rdata);
        chk({tag, "_err"}, 64'(bus.resp_err), 64'(got_e.err));
        chk({tag, "_strobes"}, 64'(strobe_cnt), (got_e.mode != 2'd0) ? 64'd1 : 64'd0);
        if (got_e.mode != 2'd0) chk({tag, "_mode"}, 64'(strobe_mode), 64'(got_e.mode));
        if (got_e.mode == 2'd3) chk({tag, "_wdata"}, strobe_wdata, got_e.wdata);
        if (hold > 0) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 64'h0200_BFF8;
            bus.req_wen   = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, "_hold_rdata"}, bus.resp_rdata, got_e.rdata);
                chk({tag, "_hold_err"}, 64'(bus.resp_err), 64'(got_e.err));
                chk({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
                chk({tag, "_hold_rdy"}, 64'(bus.req_ready), 64'd0);
            end
            chk({tag, "_hold_nostrobe"}, 64'(strobe_cnt), (got_e.mode != 2'd0) ? 64'd1 : 64'd0);
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_done_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, "_done_rdy"}, 64'(bus.req_ready), 64'd1);
    endtask

    typedef struct {
        logic [63:0] addr;
        string       name;
    } fault_t;

    initial begin
        fault_t faults[5];
        bit saw_valid = 0;
        faults[0] = '{64'h0200_4004, "misaligned"};
        faults[1] = '{64'h0300_4000, "outside"};
        faults[2] = '{64'h0200_0000, "unmapped"};
        faults[3] = '{64'h0200_FFF8, "top_of_window"};
        faults[4] = '{64'h0201_0000, "past_window"};

        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        bus.resp_ready = 1'b1;

        #3;
        chk("rst_enable", 64'(tmr_enable), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_mode", 64'(tmr_rw_mode), 64'd0);
        chk("rst_wdata", tmr_wdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_enable", 64'(tmr_enable), 64'd1);
            chk("idle_mode", 64'(tmr_rw_mode), 64'd0);
            chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
        end

        do_txn("st_cmp", 1'b1, 64'h0200_4000, 64'h64, 64'd0, 1'b0, 2'd3, 0);
        mtimecmp_val = 64'hDEAD_BEEF_0000_0064;
        do_txn("ld_cmp", 1'b0, 64'h0200_4000, 64'd0, 64'hDEAD_BEEF_0000_0064, 1'b0, 2'd2, 0);
        mtime_val = 64'h1;
        do_txn("ld_time", 1'b0, 64'h0200_BFF8, 64'd0, 64'h1, 1'b0, 2'd1, 0);
        do_txn("st_time", 1'b1, 64'h0200_BFF8, 64'h55, 64'd0, 1'b1, 2'd0, 0);
        chk("wdata_held", tmr_wdata, 64'h55);
        foreach (faults[i])
            do_txn(faults[i].name, 1'b0, faults[i].addr, 64'd0, 64'd0, 1'b1, 2'd0, 0);
        mtime_val = 64'h0000_0123_4567_89AB;
        do_txn("ld_hold", 1'b0, 64'h0200_BFF8, 64'd0, 64'h0000_0123_4567_89AB, 1'b0, 2'd1, 5);

        // Store aborted by reset while its strobe is on the wires.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 64'h0200_4000;
        bus.req_wdata = 64'h99;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("abort_pre_mode", 64'(tmr_rw_mode), 64'd3);
        #1 rst = 1'b0;
        #1;
        strobe_cnt = 0;
        chk("abort_mode", 64'(tmr_rw_mode), 64'd0);
        chk("abort_enable", 64'(tmr_enable), 64'd0);
        chk("abort_req_ready", 64'(bus.req_ready), 64'd0);
        chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("abort_rdata", bus.resp_rdata, 64'd0);
        chk("abort_err", 64'(bus.resp_err), 64'd0);
        chk("abort_wdata", tmr_wdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid) saw_valid = 1;
        end
        chk("abort_no_resp", 64'(saw_valid), 64'd0);
        chk("abort_no_strobe", 64'(strobe_cnt), 64'd0);
        chk("abort_enable_back", 64'(tmr_enable), 64'd1);
        do_txn("post_abort", 1'b0, 64'h0200_4000, 64'd0, 64'hDEAD_BEEF_0000_0064, 1'b0, 2'd2, 0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
